store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//   Posted-write buffer on the cpu data-memory port, directly downstream of the core.
//   Captures stores (memwrite/aluout/writedata) into a FIFO in one cycle.
//   Drains entries to the backing data memory over a valid/ready write channel.
//   Loads forward the youngest matching buffered store; otherwise they pass backing
//   read data through combinationally, so the single-cycle core sees zero added
//   load latency.
// PARAMETERS
//   WIDTH  32  data/address word width (matches `WORD)
//   DEPTH  4   buffer entries; power of two, >= 2
// PORTS
//   clk        in   1      clock, all state updates on posedge
//   reset      in   1      synchronous, active-high
//   memwrite   in   1      core store request this cycle
//   aluout     in   WIDTH  core data address (load or store)
//   writedata  in   WIDTH  core store data
//   readdata   out  WIDTH  load data returned to core
//   stall      out  1      store refused (buffer full); core must hold pc
//   buf_empty  out  1      no pending stores (used for halt/fence)
//   mem_wvalid out  1      head entry presented to memory
//   mem_wready in   1      memory accepts head entry this cycle
//   mem_waddr  out  WIDTH  head entry address
//   mem_wdata  out  WIDTH  head entry data
//   mem_raddr  out  WIDTH  backing read address (= aluout)
//   mem_rdata  in   WIDTH  backing read data (combinational memory)
// BEHAVIOUR
//   State
//   - Circular FIFO: wr_ptr, rd_ptr (log2(DEPTH) bits, wrap modulo DEPTH).
//   - count: 0..DEPTH, log2(DEPTH)+1 bits.
//   - Per-entry {addr, data}. No valid bits; occupancy is derived from count.
//   Reset
//   - wr_ptr = rd_ptr = count = 0.
//   - Hence mem_wvalid = 0, stall = 0, buf_empty = 1.
//   - Entry storage is not cleared.
//   - Reset mid-drain discards all pending stores, and mem_wvalid drops the next cycle.
//   Enqueue
//   - Occurs when memwrite && count < DEPTH.
//   - Writes {aluout, writedata} at wr_ptr; wr_ptr++ at the edge.
//   Stall
//   - stall = memwrite && count == DEPTH; combinational, no dependence on mem_wready.
//   - A stalled store is not captured. The core re-presents it next cycle.
//   Dequeue
//   - mem_wvalid = (count != 0); mem_waddr/mem_wdata = entry[rd_ptr].
//   - On mem_wvalid && mem_wready: rd_ptr++ at the edge.
//   - Outputs stay stable while valid && !ready.
//   Count
//   - enq && deq: unchanged. enq only: +1. deq only: -1.
//   - Never exceeds DEPTH and never underflows.
//   buf_empty = (count == 0).
//   Load forwarding (combinational)
//   - Compare aluout[WIDTH-1:2] against each occupied entry's addr[WIDTH-1:2].
//   - Youngest match wins, i.e. the closest to wr_ptr-1 going backwards.
//   - readdata = match ? that entry's data : mem_rdata.
//   - An entry being dequeued this cycle still forwards; it is only removed at the edge.
//   - A store entering this cycle is not visible to a load in the same cycle.
//   mem_raddr = aluout, unconditionally.
//   Ordering
//   - Memory receives stores in program order, exactly once each.
// TESTING
//   1. Reset, idle -> mem_wvalid=0, buf_empty=1, stall=0,
//      readdata tracks mem_rdata (0x1234 in -> 0x1234 out).
//   2. mem_wready=1, store A=0x10 D=0xAA -> next cycle mem_wvalid=1,
//      waddr=0x10, wdata=0xAA; one cycle later buf_empty=1.
//   3. mem_wready=0, 4 stores to 0x0,0x4,0x8,0xC -> count=4; a 5th store gives stall=1
//      and is not captured; raise wready -> drains 0x0,0x4,0x8,0xC in order.
//   4. wready=0, stores 0x20<-0x1 then 0x20<-0x2, load 0x20 with mem_rdata=0xFF
//      -> readdata=0x2; load 0x24 -> readdata=0xFF.
//   5. count=2, wready=1 with a simultaneous store -> count stays 2;
//      pointers wrap correctly across 10 such cycles with order preserved.
//   6. count=3, wready=0, assert reset one cycle -> next cycle buf_empty=1,
//      mem_wvalid=0; none of the 3 stores ever appear on mem_w*.

Source files
------------

// File: rtl/store_buffer.sv
// Posted-write buffer between the core data port and backing memory.
// Stores enter a circular FIFO in one cycle; loads forward the youngest buffered match.
module store_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] aluout,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    output logic             stall,
    output logic             buf_empty,
    output logic             mem_wvalid,
    input  logic             mem_wready,
    output logic [WIDTH-1:0] mem_waddr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [WIDTH-1:0] mem_raddr,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] entry_addr [DEPTH];
    logic [WIDTH-1:0] entry_data [DEPTH];

    logic             enq;
    logic             deq;
    logic             fwd_hit;
    logic [WIDTH-1:0] fwd_data;
    logic [PTR_W-1:0] idx;

    assign mem_wvalid = (count != '0);
    assign buf_empty  = (count == '0);
    // Stall depends only on occupancy so the core never sees a combinational path from mem_wready.
    assign stall      = memwrite && (count == FULL);
    assign enq        = memwrite && (count < FULL);
    assign deq        = mem_wvalid && mem_wready;

    assign mem_waddr  = entry_addr[rd_ptr];
    assign mem_wdata  = entry_data[rd_ptr];
    assign mem_raddr  = aluout;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry payload is never cleared; occupancy comes solely from count.
    always_ff @(posedge clk) begin
        if (enq) begin
            entry_addr[wr_ptr] <= aluout;
            entry_data[wr_ptr] <= writedata;
        end
    end

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) &&
                (entry_addr[idx][WIDTH-1:2] == aluout[WIDTH-1:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = entry_data[idx];
            end
        end
    end

    assign readdata = fwd_hit ? fwd_data : mem_rdata;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus randomized traffic against a queue model.
module tb_store_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        stall;
    logic        buf_empty;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;

    int checks = 0;
    int passes = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    store_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .aluout(aluout),
        .writedata(writedata), .readdata(readdata), .stall(stall),
        .buf_empty(buf_empty), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [31:0] rd);
        model_read = rd;
        for (int i = 0; i < q.size(); i++)
            if (q[i].addr[31:2] == a[31:2]) model_read = q[i].data;
    endfunction

    task automatic tick();
        bit   do_deq;
        bit   do_enq;
        ent_t e;
        @(posedge clk);
        if (reset) begin
            q.delete();
        end else begin
            do_deq = (q.size() != 0) && mem_wready;
            do_enq = memwrite && (q.size() < DEPTH);
            if (do_deq) void'(q.pop_front());
            if (do_enq) begin
                e.addr = aluout;
                e.data = writedata;
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1; aluout = a; writedata = d;
        tick();
        memwrite = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; memwrite = 1'b0; mem_wready = 1'b0;
        aluout = 32'h40; writedata = 32'h0; mem_rdata = 32'h1234;
        tick(); tick();
        reset = 1'b0;
        #1;
        checks++; if (mem_wvalid !== 1'b0) $display("FAIL reset_wvalid got=%b exp=0", mem_wvalid); else passes++;
        checks++; if (buf_empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", buf_empty); else passes++;
        checks++; if (stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall); else passes++;
        checks++; if (readdata !== 32'h1234) $display("FAIL reset_readdata got=%h exp=1234", readdata); else passes++;
        checks++; if (mem_raddr !== 32'h40) $display("FAIL reset_raddr got=%h exp=40", mem_raddr); else passes++;
    endtask

    task automatic test_single_store();
        mem_wready = 1'b1;
        store(32'h10, 32'hAA);
        #1;
        checks++; if (mem_wvalid !== 1'b1) $display("FAIL single_wvalid got=%b exp=1", mem_wvalid); else passes++;
        checks++; if (mem_waddr !== 32'h10) $display("FAIL single_waddr got=%h exp=10", mem_waddr); else passes++;
        checks++; if (mem_wdata !== 32'hAA) $display("FAIL single_wdata got=%h exp=aa", mem_wdata); else passes++;
        checks++; if (buf_empty !== 1'b0) $display("FAIL single_busy got=%b exp=0", buf_empty); else passes++;
        tick();
        checks++; if (buf_empty !== 1'b1) $display("FAIL single_drained got=%b exp=1", buf_empty); else passes++;
    endtask

    task automatic test_full_stall();
        mem_wready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            memwrite = 1'b1; aluout = 32'(4 * i); writedata = 32'h100 + 32'(i);
            #1;
            checks++; if (stall !== 1'b0) $display("FAIL fill_stall i=%0d got=%b exp=0", i, stall); else passes++;
            tick();
        end
        memwrite = 1'b1; aluout = 32'h30; writedata = 32'hDEAD;
        #1;
        checks++; if (stall !== 1'b1) $display("FAIL full_stall got=%b exp=1", stall); else passes++;
        mem_wready = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) $display("FAIL full_stall_ready got=%b exp=1", stall); else passes++;
        mem_wready = 1'b0;
        tick();
        memwrite = 1'b0; mem_wready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (mem_waddr !== 32'(4 * i)) $display("FAIL drain_addr i=%0d got=%h exp=%h", i, mem_waddr, 4 * i); else passes++;
            checks++; if (mem_wdata !== 32'h100 + 32'(i)) $display("FAIL drain_data i=%0d got=%h exp=%h", i, mem_wdata, 32'h100 + i); else passes++;
            tick();
        end
        checks++; if (buf_empty !== 1'b1) $display("FAIL stalled_store_dropped got=%b exp=1", buf_empty); else passes++;
    endtask

    task automatic test_forwarding();
        mem_wready = 1'b0; mem_rdata = 32'hFF;
        store(32'h20, 32'h1);
        store(32'h20, 32'h2);
        aluout = 32'h20; #1;
        checks++; if (readdata !== 32'h2) $display("FAIL fwd_youngest got=%h exp=2", readdata); else passes++;
        aluout = 32'h23; #1;
        checks++; if (readdata !== 32'h2) $display("FAIL fwd_word got=%h exp=2", readdata); else passes++;
        aluout = 32'h24; #1;
        checks++; if (readdata !== 32'hFF) $display("FAIL fwd_miss got=%h exp=ff", readdata); else passes++;
        memwrite = 1'b1; writedata = 32'h77; #1;
        checks++; if (readdata !== 32'hFF) $display("FAIL fwd_same_cycle got=%h exp=ff", readdata); else passes++;
        tick();
        memwrite = 1'b0; #1;
        checks++; if (readdata !== 32'h77) $display("FAIL fwd_next_cycle got=%h exp=77", readdata); else passes++;
        mem_wready = 1'b1; aluout = 32'h20; #1;
        checks++; if (readdata !== 32'h2) $display("FAIL fwd_during_deq got=%h exp=2", readdata); else passes++;
        for (int k = 0; k < 8 && q.size() != 0; k++) tick();
        checks++; if (buf_empty !== 1'b1) $display("FAIL fwd_drain got=%b exp=1", buf_empty); else passes++;
    endtask

    task automatic test_back_to_back();
        mem_wready = 1'b0;
        store(32'h200, 32'h600);
        store(32'h204, 32'h601);
        for (int k = 0; k < 10; k++) begin
            memwrite = 1'b1; mem_wready = 1'b1;
            aluout = 32'h100 + 32'(4 * k); writedata = 32'h500 + 32'(k);
            #1;
            checks++; if (mem_waddr !== q[0].addr) $display("FAIL b2b_addr k=%0d got=%h exp=%h", k, mem_waddr, q[0].addr); else passes++;
            checks++; if (mem_wdata !== q[0].data) $display("FAIL b2b_data k=%0d got=%h exp=%h", k, mem_wdata, q[0].data); else passes++;
            checks++; if (stall !== 1'b0) $display("FAIL b2b_stall k=%0d got=%b exp=0", k, stall); else passes++;
            tick();
        end
        memwrite = 1'b0; mem_wready = 1'b1;
        for (int k = 8; k < 10; k++) begin
            #1;
            checks++; if (mem_waddr !== 32'h100 + 32'(4 * k)) $display("FAIL b2b_tail_addr k=%0d got=%h exp=%h", k, mem_waddr, 32'h100 + 4 * k); else passes++;
            checks++; if (mem_wvalid !== 1'b1) $display("FAIL b2b_tail_valid k=%0d got=%b exp=1", k, mem_wvalid); else passes++;
            tick();
        end
        checks++; if (buf_empty !== 1'b1) $display("FAIL b2b_count got=%b exp=1", buf_empty); else passes++;
    endtask

    task automatic test_reset_mid_drain();
        mem_wready = 1'b0;
        store(32'h300, 32'h1);
        store(32'h304, 32'h2);
        store(32'h308, 32'h3);
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        checks++; if (buf_empty !== 1'b1) $display("FAIL rst_drain_empty got=%b exp=1", buf_empty); else passes++;
        checks++; if (mem_wvalid !== 1'b0) $display("FAIL rst_drain_wvalid got=%b exp=0", mem_wvalid); else passes++;
        mem_wready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (mem_wvalid !== 1'b0) $display("FAIL rst_drain_ghost k=%0d got=%b exp=0", k, mem_wvalid); else passes++;
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_rd;
        for (int c = 0; c < 400; c++) begin
            memwrite   = ($urandom_range(0, 99) < 60);
            aluout     = 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
            writedata  = $urandom;
            mem_wready = ($urandom_range(0, 99) < 45);
            mem_rdata  = $urandom;
            reset      = ($urandom_range(0, 59) == 0);
            #1;
            exp_rd = model_read(aluout, mem_rdata);
            checks++; if (readdata !== exp_rd) $display("FAIL rand_readdata c=%0d got=%h exp=%h", c, readdata, exp_rd); else passes++;
            checks++; if (stall !== (memwrite && q.size() == DEPTH)) $display("FAIL rand_stall c=%0d got=%b", c, stall); else passes++;
            checks++; if (buf_empty !== (q.size() == 0)) $display("FAIL rand_empty c=%0d got=%b", c, buf_empty); else passes++;
            checks++; if (mem_wvalid !== (q.size() != 0)) $display("FAIL rand_wvalid c=%0d got=%b", c, mem_wvalid); else passes++;
            checks++; if (mem_raddr !== aluout) $display("FAIL rand_raddr c=%0d got=%h exp=%h", c, mem_raddr, aluout); else passes++;
            if (q.size() != 0) begin
                checks++; if (mem_waddr !== q[0].addr) $display("FAIL rand_waddr c=%0d got=%h exp=%h", c, mem_waddr, q[0].addr); else passes++;
                checks++; if (mem_wdata !== q[0].data) $display("FAIL rand_wdata c=%0d got=%h exp=%h", c, mem_wdata, q[0].data); else passes++;
            end
            tick();
        end
        reset = 1'b0; memwrite = 1'b0;
    endtask

    initial begin
        reset = 1'b1; memwrite = 1'b0; mem_wready = 1'b0;
        aluout = '0; writedata = '0; mem_rdata = '0;
        test_reset();
        test_single_store();
        test_full_stall();
        test_forwarding();
        test_back_to_back();
        test_reset_mid_drain();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
